// File: rtl/vadd_result_writeback_pkg.sv
// Shared types and sizes for the vector-add result writeback slice.
// Holds state encoding, default widths and the rf address width.
package vadd_result_writeback_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_ELEM = 16;
  localparam int IDX_W    = 4;
  localparam int VREG_W   = 3;
  localparam int ADDR_W   = VREG_W + IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_FLAG,
    S_DONE
  } state_e;

endpackage

// File: rtl/vadd_elem_buffer.sv
// Element buffer: NUM_ELEM x DATA_W registers, no reset.
// Ports: Clk, we/widx/wdata write port, ridx -> rdata async read.
module vadd_elem_buffer #(
  parameter int DATA_W   = 16,
  parameter int NUM_ELEM = 16,
  parameter int IDX_W    = 4
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [NUM_ELEM];

  always_ff @(posedge Clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/vadd_result_writeback.sv
// Collects adder sums, drains them to the vector RF, writes ovf flag.
// Ports: start/dest_reg/elem_*/ov_in in, rf_* + ovf_* + status out.
module vadd_result_writeback
  import vadd_result_writeback_pkg::*;
#(
  parameter int DATA_W   = vadd_result_writeback_pkg::DATA_W,
  parameter int NUM_ELEM = vadd_result_writeback_pkg::NUM_ELEM,
  parameter int IDX_W    = vadd_result_writeback_pkg::IDX_W,
  parameter int VREG_W   = vadd_result_writeback_pkg::VREG_W
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    start,
  input  logic [VREG_W-1:0]       dest_reg,
  input  logic [DATA_W-1:0]       elem_in,
  input  logic                    elem_write,
  input  logic                    ov_in,
  input  logic                    elem_done,
  input  logic                    rf_grant,
  output logic                    rf_we,
  output logic [VREG_W+IDX_W-1:0] rf_addr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic                    ovf_we,
  output logic                    ovf_data,
  output logic                    busy,
  output logic                    complete,
  output logic                    overrun
);

  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(NUM_ELEM);
  localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);

  state_e              state;
  logic [VREG_W-1:0]   dest_q;
  logic [IDX_W:0]      wr_cnt;
  logic [IDX_W-1:0]    rd_idx;
  logic                ovf;

  logic                cap;
  logic [IDX_W:0]      cnt_nxt;
  logic                ovf_nxt;
  logic                last;
  logic [IDX_W-1:0]    rd_nxt;
  logic [IDX_W-1:0]    ridx;
  logic [DATA_W-1:0]   rdata;
  logic                buf_we;

  assign cap     = elem_write && (wr_cnt < FULL);
  assign cnt_nxt = wr_cnt + {{IDX_W{1'b0}}, cap};
  assign ovf_nxt = ovf | (elem_write & ov_in);
  assign last    = ({1'b0, rd_idx} == (wr_cnt - ONE));
  assign rd_nxt  = rd_idx + IDX_W'(1);
  assign ridx    = (state == S_DRAIN) ? rd_nxt : '0;
  assign buf_we  = (state == S_COLLECT) && cap;

  vadd_elem_buffer #(
    .DATA_W  (DATA_W),
    .NUM_ELEM(NUM_ELEM),
    .IDX_W   (IDX_W)
  ) u_buf (
    .Clk  (Clk),
    .we   (buf_we),
    .widx (wr_cnt[IDX_W-1:0]),
    .wdata(elem_in),
    .ridx (ridx),
    .rdata(rdata)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_IDLE;
      dest_q   <= '0;
      wr_cnt   <= '0;
      rd_idx   <= '0;
      ovf      <= 1'b0;
      overrun  <= 1'b0;
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      ovf_we   <= 1'b0;
      ovf_data <= 1'b0;
      busy     <= 1'b0;
      complete <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            dest_q   <= dest_reg;
            wr_cnt   <= '0;
            rd_idx   <= '0;
            ovf      <= 1'b0;
            overrun  <= 1'b0;
            ovf_data <= 1'b0;
            busy     <= 1'b1;
            state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (!start) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            wr_cnt <= cnt_nxt;
            ovf    <= ovf_nxt;
            if (elem_write && !cap) overrun <= 1'b1;
            if (elem_done || cnt_nxt == FULL) begin
              if (cnt_nxt != '0) begin
                state   <= S_DRAIN;
                rf_we   <= 1'b1;
                rf_addr <= {dest_q, {IDX_W{1'b0}}};
                // element 0 may be landing in the buffer this cycle
                rf_wdata <= (wr_cnt == '0) ? elem_in : rdata;
              end else begin
                state    <= S_FLAG;
                ovf_we   <= 1'b1;
                ovf_data <= ovf_nxt;
              end
            end
          end
        end
        S_DRAIN: begin
          if (!start) begin
            state <= S_IDLE;
            rf_we <= 1'b0;
            busy  <= 1'b0;
          end else if (rf_grant) begin
            if (last) begin
              state    <= S_FLAG;
              rf_we    <= 1'b0;
              ovf_we   <= 1'b1;
              ovf_data <= ovf;
            end else begin
              rd_idx   <= rd_nxt;
              rf_addr  <= {dest_q, rd_nxt};
              rf_wdata <= rdata;
            end
          end
        end
        S_FLAG: begin
          ovf_we <= 1'b0;
          busy   <= 1'b0;
          if (!start) begin
            state <= S_IDLE;
          end else begin
            state    <= S_DONE;
            complete <= 1'b1;
          end
        end
        S_DONE: begin
          if (!start) begin
            state    <= S_IDLE;
            complete <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
